// File: rtl/data_path_pkg.sv
// Shared definitions for the data path core: ALU opcodes, IR field positions
// and the branch condition codes held in the C2 field.
package data_path_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_SHR  = 5'b00111,
    OP_SHRA = 5'b01000,
    OP_SHL  = 5'b01001,
    OP_ROR  = 5'b01010,
    OP_ROL  = 5'b01011,
    OP_MUL  = 5'b01110,
    OP_DIV  = 5'b01111,
    OP_NEG  = 5'b10000,
    OP_NOT  = 5'b10001
  } alu_op_e;

  typedef enum logic [1:0] {
    C2_ZERO    = 2'b00,
    C2_NONZERO = 2'b01,
    C2_POS     = 2'b10,
    C2_NEG     = 2'b11
  } cond_e;

  localparam int IR_RA_MSB = 26;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RC_MSB = 18;
  localparam int IR_C2_MSB = 20;
  localparam int IR_C_MSB  = 18;

  function automatic logic [31:0] signExtC(input logic [31:0] ir);
    return {{(31 - IR_C_MSB){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};
  endfunction

endpackage

// File: rtl/dp_alu.sv
// 64-bit result ALU for the data path core (A from Y, B from the bus).
// Multiply and divide exist only when MULDIV_EN is defined.
module dp_alu
  import data_path_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_op,
  input  logic        i_incPc,
  output logic [63:0] o_result
);

  logic [4:0] w_shAmt;
  logic [5:0] w_shInv;

  assign w_shAmt = i_b[4:0];
  assign w_shInv = 6'd32 - {1'b0, w_shAmt};

`ifdef MULDIV_EN
  logic signed [63:0] w_prod;
  logic        [31:0] w_divisor;
  logic signed [31:0] w_quo;
  logic signed [31:0] w_rem;

  assign w_prod    = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  // Divisor is forced non-zero so the divider never sees zero; result is muxed to 0 below.
  assign w_divisor = (i_b == 32'd0) ? 32'd1 : i_b;
  assign w_quo     = $signed(i_a) / $signed(w_divisor);
  assign w_rem     = $signed(i_a) % $signed(w_divisor);
`endif

  always_comb begin
    o_result = 64'd0;
    if (i_incPc) begin
      o_result[31:0] = i_b + 32'd1;
    end else begin
      case (i_op)
        OP_ADD:  o_result[31:0] = i_a + i_b;
        OP_SUB:  o_result[31:0] = i_a - i_b;
        OP_AND:  o_result[31:0] = i_a & i_b;
        OP_OR:   o_result[31:0] = i_a | i_b;
        OP_SHR:  o_result[31:0] = i_a >> w_shAmt;
        OP_SHRA: o_result[31:0] = $signed(i_a) >>> w_shAmt;
        OP_SHL:  o_result[31:0] = i_a << w_shAmt;
        OP_ROR:  o_result[31:0] = (i_a >> w_shAmt) | (i_a << w_shInv);
        OP_ROL:  o_result[31:0] = (i_a << w_shAmt) | (i_a >> w_shInv);
`ifdef MULDIV_EN
        OP_MUL:  o_result = w_prod;
        OP_DIV:  o_result = (i_b == 32'd0) ? 64'd0 : {w_rem, w_quo};
`endif
        OP_NEG:  o_result[31:0] = 32'd0 - i_b;
        OP_NOT:  o_result[31:0] = ~i_b;
        default: o_result = 64'd0;
      endcase
    end
  end

endmodule

// File: rtl/data_path_core.sv
// Single-bus processor data path: register file, Y/Z/HI/LO, PC/IR, MAR/MDR, RAM,
// in/out ports and the CON branch flag. MULDIV_EN enables the ALU mul/div ops.
module data_path_core
  import data_path_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        Write,
  input  logic        strobe,
  input  logic        BAOut,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        CONin,
  input  logic [31:0] input_data,
  input  logic        IRin,
  input  logic [4:0]  op,
  input  logic        HIOut,
  input  logic        LOout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic        Yout,
  input  logic        RAMout,
  input  logic        Cout,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighin,
  input  logic        Zlowin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        OutPortin,
  input  logic        Yin,
  input  logic        MARin,
  input  logic        IncPC,
  output logic [31:0] BusOut,
  output logic [31:0] mdrData,
  output logic [31:0] ZHighWire,
  output logic [31:0] ZLowWire,
  output logic [31:0] BusMuxInR0,
  output logic [31:0] BusMuxInR1,
  output logic [31:0] BusMuxInR2,
  output logic [31:0] BusMuxInR3,
  output logic [31:0] BusMuxInR4,
  output logic [31:0] BusMuxInR5,
  output logic [31:0] BusMuxInR6,
  output logic [31:0] BusMuxInR7,
  output logic [31:0] BusMuxInR8,
  output logic [31:0] BusMuxInR9,
  output logic [31:0] BusMuxInR10,
  output logic [31:0] BusMuxInR11,
  output logic [31:0] BusMuxInR12,
  output logic [31:0] BusMuxInR13,
  output logic [31:0] BusMuxInR14,
  output logic [31:0] BusMuxInR15,
  output logic [31:0] BusMuxInZhigh,
  output logic [31:0] BusMuxInZlow,
  output logic [31:0] BusMuxInPCout,
  output logic [31:0] BusMuxInInPortout,
  output logic [31:0] BusMuxInYout,
  output logic [31:0] BusMuxInHI,
  output logic [31:0] BusMuxInLO,
  output logic [31:0] BusMuxInRamout,
  output logic [31:0] output_data,
  output logic [31:0] irOut,
  output logic        branchCompare,
  output logic R0out, output logic R1out, output logic R2out, output logic R3out,
  output logic R4out, output logic R5out, output logic R6out, output logic R7out,
  output logic R8out, output logic R9out, output logic R10out, output logic R11out,
  output logic R12out, output logic R13out, output logic R14out, output logic R15out,
  output logic R0in, output logic R1in, output logic R2in, output logic R3in,
  output logic R4in, output logic R5in, output logic R6in, output logic R7in,
  output logic R8in, output logic R9in, output logic R10in, output logic R11in,
  output logic R12in, output logic R13in, output logic R14in, output logic R15in,
  output logic [3:0]  to_decode
);

  logic [31:0]       r_regs [16];
  logic [31:0]       r_hi, r_lo, r_y, r_zHigh, r_zLow, r_pc, r_ir, r_mdr;
  logic [31:0]       r_inPort, r_outPort;
  logic [ADDR_W-1:0] r_mar;
  logic              r_con;
  logic [31:0]       r_mem [2**ADDR_W];

  logic [3:0]  w_sel;
  logic [15:0] w_oneHot, w_rIn, w_rOut;
  logic [31:0] w_bus, w_ramData, w_cSext;
  logic [63:0] w_aluResult;

  // Register-field select: Ra beats Rb beats Rc.
  always_comb begin
    w_sel = 4'd0;
    if (Gra)      w_sel = r_ir[IR_RA_MSB -: 4];
    else if (Grb) w_sel = r_ir[IR_RB_MSB -: 4];
    else if (Grc) w_sel = r_ir[IR_RC_MSB -: 4];
  end

  assign w_oneHot  = 16'd1 << w_sel;
  assign w_rIn     = {16{Rin}} & w_oneHot;
  assign w_rOut    = {16{Rout | BAOut}} & w_oneHot;
  assign w_ramData = r_mem[r_mar];
  assign w_cSext   = signExtC(r_ir);

  // BAOut on R0 reads as zero so base-address mode can mean "no base".
  always_comb begin
    w_bus = 32'd0;
    if (|w_rOut)        w_bus = (BAOut && w_rOut[0]) ? 32'd0 : r_regs[w_sel];
    else if (HIOut)     w_bus = r_hi;
    else if (LOout)     w_bus = r_lo;
    else if (Zhighout)  w_bus = r_zHigh;
    else if (Zlowout)   w_bus = r_zLow;
    else if (PCout)     w_bus = r_pc;
    else if (MDRout)    w_bus = r_mdr;
    else if (InPortout) w_bus = r_inPort;
    else if (Yout)      w_bus = r_y;
    else if (RAMout)    w_bus = w_ramData;
    else if (Cout)      w_bus = w_cSext;
  end

  dp_alu u_alu (
    .i_a      (r_y),
    .i_b      (w_bus),
    .i_op     (op),
    .i_incPc  (IncPC),
    .o_result (w_aluResult)
  );

  always_ff @(posedge Clock) begin
    if (!clear) begin
      for (int k = 0; k < 16; k++) r_regs[k] <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_y       <= 32'd0;
      r_zHigh   <= 32'd0;
      r_zLow    <= 32'd0;
      r_pc      <= 32'd0;
      r_ir      <= 32'd0;
      r_mdr     <= 32'd0;
      r_mar     <= '0;
      r_inPort  <= 32'd0;
      r_outPort <= 32'd0;
      r_con     <= 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (w_rIn[k]) r_regs[k] <= w_bus;
      end
      if (HIin)      r_hi      <= w_bus;
      if (LOin)      r_lo      <= w_bus;
      if (Yin)       r_y       <= w_bus;
      if (ZHighin)   r_zHigh   <= w_aluResult[63:32];
      if (Zlowin)    r_zLow    <= w_aluResult[31:0];
      if (PCin)      r_pc      <= w_bus;
      if (IRin)      r_ir      <= w_bus;
      if (MDRin)     r_mdr     <= Read ? w_ramData : w_bus;
      if (MARin)     r_mar     <= w_bus[ADDR_W-1:0];
      if (strobe)    r_inPort  <= input_data;
      if (OutPortin) r_outPort <= w_bus;
      if (CONin) begin
        case (cond_e'(r_ir[IR_C2_MSB -: 2]))
          C2_ZERO:    r_con <= (w_bus == 32'd0);
          C2_NONZERO: r_con <= (w_bus != 32'd0);
          C2_POS:     r_con <= ~w_bus[31];
          C2_NEG:     r_con <= w_bus[31];
          default:    r_con <= 1'b0;
        endcase
      end
    end
  end

  // RAM keeps its contents through reset; a write stores the MDR value from before this edge.
  always_ff @(posedge Clock) begin
    if (clear && Write) r_mem[r_mar] <= r_mdr;
  end

  assign BusOut            = w_bus;
  assign mdrData           = r_mdr;
  assign ZHighWire         = r_zHigh;
  assign ZLowWire          = r_zLow;
  assign BusMuxInZhigh     = r_zHigh;
  assign BusMuxInZlow      = r_zLow;
  assign BusMuxInPCout     = r_pc;
  assign BusMuxInInPortout = r_inPort;
  assign BusMuxInYout      = r_y;
  assign BusMuxInHI        = r_hi;
  assign BusMuxInLO        = r_lo;
  assign BusMuxInRamout    = w_ramData;
  assign output_data       = r_outPort;
  assign irOut             = r_ir;
  assign branchCompare     = r_con;
  assign to_decode         = w_sel;

  assign BusMuxInR0  = r_regs[0];
  assign BusMuxInR1  = r_regs[1];
  assign BusMuxInR2  = r_regs[2];
  assign BusMuxInR3  = r_regs[3];
  assign BusMuxInR4  = r_regs[4];
  assign BusMuxInR5  = r_regs[5];
  assign BusMuxInR6  = r_regs[6];
  assign BusMuxInR7  = r_regs[7];
  assign BusMuxInR8  = r_regs[8];
  assign BusMuxInR9  = r_regs[9];
  assign BusMuxInR10 = r_regs[10];
  assign BusMuxInR11 = r_regs[11];
  assign BusMuxInR12 = r_regs[12];
  assign BusMuxInR13 = r_regs[13];
  assign BusMuxInR14 = r_regs[14];
  assign BusMuxInR15 = r_regs[15];

  assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
          R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = w_rOut;
  assign {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
          R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in} = w_rIn;

endmodule

// File: tb/tb_data_path_core.sv
// Scoreboard bench for data_path_core: expected values are queued as each
// micro-step is driven and popped once the step's result is visible.
module tb_data_path_core;

  logic Clock, clear, Read, Write, strobe, BAOut, Gra, Grb, Grc, Rin, Rout, CONin;
  logic [31:0] input_data;
  logic IRin;
  logic [4:0] op;
  logic HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout;
  logic HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC;

  wire [31:0] BusOut, mdrData, ZHighWire, ZLowWire;
  wire [31:0] busR [16];
  wire [31:0] BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout, BusMuxInInPortout;
  wire [31:0] BusMuxInYout, BusMuxInHI, BusMuxInLO, BusMuxInRamout;
  wire [31:0] output_data, irOut;
  wire        branchCompare;
  wire [15:0] rOutV, rInV;
  wire [3:0]  to_decode;

  int checks = 0;
  int failures = 0;
  logic [31:0] sbQ [$];
  logic [31:0] exp;

  data_path_core dut (
    .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .strobe(strobe),
    .BAOut(BAOut), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .CONin(CONin), .input_data(input_data), .IRin(IRin), .op(op),
    .HIOut(HIOut), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout),
    .RAMout(RAMout), .Cout(Cout), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin),
    .Zlowin(Zlowin), .PCin(PCin), .MDRin(MDRin), .OutPortin(OutPortin),
    .Yin(Yin), .MARin(MARin), .IncPC(IncPC),
    .BusOut(BusOut), .mdrData(mdrData), .ZHighWire(ZHighWire), .ZLowWire(ZLowWire),
    .BusMuxInR0(busR[0]), .BusMuxInR1(busR[1]), .BusMuxInR2(busR[2]), .BusMuxInR3(busR[3]),
    .BusMuxInR4(busR[4]), .BusMuxInR5(busR[5]), .BusMuxInR6(busR[6]), .BusMuxInR7(busR[7]),
    .BusMuxInR8(busR[8]), .BusMuxInR9(busR[9]), .BusMuxInR10(busR[10]), .BusMuxInR11(busR[11]),
    .BusMuxInR12(busR[12]), .BusMuxInR13(busR[13]), .BusMuxInR14(busR[14]), .BusMuxInR15(busR[15]),
    .BusMuxInZhigh(BusMuxInZhigh), .BusMuxInZlow(BusMuxInZlow), .BusMuxInPCout(BusMuxInPCout),
    .BusMuxInInPortout(BusMuxInInPortout), .BusMuxInYout(BusMuxInYout),
    .BusMuxInHI(BusMuxInHI), .BusMuxInLO(BusMuxInLO), .BusMuxInRamout(BusMuxInRamout),
    .output_data(output_data), .irOut(irOut), .branchCompare(branchCompare),
    .R0out(rOutV[0]), .R1out(rOutV[1]), .R2out(rOutV[2]), .R3out(rOutV[3]),
    .R4out(rOutV[4]), .R5out(rOutV[5]), .R6out(rOutV[6]), .R7out(rOutV[7]),
    .R8out(rOutV[8]), .R9out(rOutV[9]), .R10out(rOutV[10]), .R11out(rOutV[11]),
    .R12out(rOutV[12]), .R13out(rOutV[13]), .R14out(rOutV[14]), .R15out(rOutV[15]),
    .R0in(rInV[0]), .R1in(rInV[1]), .R2in(rInV[2]), .R3in(rInV[3]),
    .R4in(rInV[4]), .R5in(rInV[5]), .R6in(rInV[6]), .R7in(rInV[7]),
    .R8in(rInV[8]), .R9in(rInV[9]), .R10in(rInV[10]), .R11in(rInV[11]),
    .R12in(rInV[12]), .R13in(rInV[13]), .R14in(rInV[14]), .R15in(rInV[15]),
    .to_decode(to_decode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    clear = 1'b1; Read = 0; Write = 0; strobe = 0; BAOut = 0; Gra = 0; Grb = 0; Grc = 0;
    Rin = 0; Rout = 0; CONin = 0; input_data = 32'd0; IRin = 0; op = 5'd0;
    HIOut = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
    InPortout = 0; Yout = 0; RAMout = 0; Cout = 0; HIin = 0; LOin = 0; ZHighin = 0;
    Zlowin = 0; PCin = 0; MDRin = 0; OutPortin = 0; Yin = 0; MARin = 0; IncPC = 0;
  endtask

  task automatic setInPort(input logic [31:0] v);
    idle(); strobe = 1; input_data = v; cycle(); idle();
  endtask

  task automatic loadIR(input logic [31:0] v);
    setInPort(v); InPortout = 1; IRin = 1; cycle(); idle();
  endtask

  task automatic loadR(input logic [3:0] idx, input logic [31:0] v);
    loadIR({5'd0, idx, 23'd0});
    setInPort(v); InPortout = 1; Gra = 1; Rin = 1; cycle(); idle();
  endtask

  task automatic loadY(input logic [31:0] v);
    setInPort(v); InPortout = 1; Yin = 1; cycle(); idle();
  endtask

  task automatic writeMem(input logic [31:0] addr, input logic [31:0] v);
    setInPort(addr); InPortout = 1; MARin = 1; cycle();
    setInPort(v); InPortout = 1; MDRin = 1; cycle(); idle();
    Write = 1; cycle(); idle();
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] o, input logic inc);
    logic [31:0] r;
    logic [63:0] p;
    logic [31:0] q, rm;
    int n;
    n = int'(b[4:0]);
    r = 32'd0;
    if (inc) return {32'd0, b + 32'd1};
    case (o)
      5'b00011: r = a + b;
      5'b00100: r = a - b;
      5'b00101: r = a & b;
      5'b00110: r = a | b;
      5'b00111: r = a >> n;
      5'b01000: begin r = a; repeat (n) r = {r[31], r[31:1]}; end
      5'b01001: r = a << n;
      5'b01010: begin r = a; repeat (n) r = {r[0], r[31:1]}; end
      5'b01011: begin r = a; repeat (n) r = {r[30:0], r[31]}; end
      5'b01110: begin
`ifdef MULDIV_EN
        p = {32'd0, mag(a)} * {32'd0, mag(b)};
        if (a[31] ^ b[31]) p = ~p + 64'd1;
        return p;
`endif
      end
      5'b01111: begin
`ifdef MULDIV_EN
        if (b == 32'd0) return 64'd0;
        q  = mag(a) / mag(b);
        rm = mag(a) % mag(b);
        if (a[31] ^ b[31]) q = ~q + 32'd1;
        if (a[31]) rm = ~rm + 32'd1;
        return {rm, q};
`endif
      end
      5'b10000: r = ~b + 32'd1;
      5'b10001: r = ~b;
      default:  r = 32'd0;
    endcase
    return {32'd0, r};
  endfunction

  task automatic test_reset();
    idle(); clear = 0; PCin = 1; InPortout = 1; cycle(); idle();
    sbQ.push_back(32'd0); sbQ.push_back(32'd0); sbQ.push_back(32'd0);
    exp = sbQ.pop_front(); checks++;
    if (BusMuxInPCout !== exp) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", BusMuxInPCout, exp); end
    exp = sbQ.pop_front(); checks++;
    if (irOut !== exp) begin failures++; $display("[TB] FAIL reset_ir got=%h exp=%h", irOut, exp); end
    exp = sbQ.pop_front(); checks++;
    if ({31'd0, branchCompare} !== exp) begin failures++; $display("[TB] FAIL reset_con got=%h exp=%h", branchCompare, exp); end
  endtask

  task automatic test_memory();
    writeMem(32'd0, 32'h0A880005);
    sbQ.push_back(32'h0A880005);
    exp = sbQ.pop_front(); checks++;
    if (BusMuxInRamout !== exp) begin failures++; $display("[TB] FAIL mem_write got=%h exp=%h", BusMuxInRamout, exp); end
    setInPort(32'd3); InPortout = 1; MARin = 1; cycle();
    setInPort(32'hAAAA0001); InPortout = 1; MDRin = 1; cycle();
    setInPort(32'hBBBB0002); InPortout = 1; MDRin = 1; Write = 1;
    sbQ.push_back(32'hAAAA0001); sbQ.push_back(32'hBBBB0002);
    cycle(); idle();
    exp = sbQ.pop_front(); checks++;
    if (BusMuxInRamout !== exp) begin failures++; $display("[TB] FAIL write_old_mdr got=%h exp=%h", BusMuxInRamout, exp); end
    exp = sbQ.pop_front(); checks++;
    if (mdrData !== exp) begin failures++; $display("[TB] FAIL mdr_from_bus got=%h exp=%h", mdrData, exp); end
    Read = 1; MDRin = 1; sbQ.push_back(32'hAAAA0001); cycle(); idle();
    exp = sbQ.pop_front(); checks++;
    if (mdrData !== exp) begin failures++; $display("[TB] FAIL mdr_read got=%h exp=%h", mdrData, exp); end
  endtask

  task automatic test_fetch();
    loadR(4'd1, 32'd7);
    sbQ.push_back(32'd7);
    exp = sbQ.pop_front(); checks++;
    if (busR[1] !== exp) begin failures++; $display("[TB] FAIL load_r1 got=%h exp=%h", busR[1], exp); end
    PCout = 1; MARin = 1; IncPC = 1; ZHighin = 1; Zlowin = 1; op = 5'b00100;
    sbQ.push_back(32'd1); sbQ.push_back(32'd0);
    cycle(); idle();
    exp = sbQ.pop_front(); checks++;
    if (ZLowWire !== exp) begin failures++; $display("[TB] FAIL incpc_zlow got=%h exp=%h", ZLowWire, exp); end
    exp = sbQ.pop_front(); checks++;
    if (ZHighWire !== exp) begin failures++; $display("[TB] FAIL incpc_zhigh got=%h exp=%h", ZHighWire, exp); end
    Zlowout = 1; PCin = 1; cycle(); idle();
    Read = 1; MDRin = 1; cycle(); idle();
    MDRout = 1; IRin = 1;
    sbQ.push_back(32'd1); sbQ.push_back(32'h0A880005);
    cycle(); idle();
    exp = sbQ.pop_front(); checks++;
    if (BusMuxInPCout !== exp) begin failures++; $display("[TB] FAIL fetch_pc got=%h exp=%h", BusMuxInPCout, exp); end
    exp = sbQ.pop_front(); checks++;
    if (irOut !== exp) begin failures++; $display("[TB] FAIL fetch_ir got=%h exp=%h", irOut, exp); end
  endtask

  task automatic test_immediate_add();
    Grb = 1; BAOut = 1; Yin = 1; sbQ.push_back(32'd7); #1;
    exp = sbQ.pop_front(); checks++;
    if (BusOut !== exp) begin failures++; $display("[TB] FAIL addi_rb_bus got=%h exp=%h", BusOut, exp); end
    cycle(); idle();
    Cout = 1; op = 5'b00011; ZHighin = 1; Zlowin = 1; sbQ.push_back(32'd5); #1;
    exp = sbQ.pop_front(); checks++;
    if (BusOut !== exp) begin failures++; $display("[TB] FAIL addi_c_bus got=%h exp=%h", BusOut, exp); end
    cycle(); idle();
    Zlowout = 1; Gra = 1; Rin = 1; sbQ.push_back(32'd5); sbQ.push_back(32'h0020); #1;
    exp = sbQ.pop_front(); checks++;
    if ({28'd0, to_decode} !== exp) begin failures++; $display("[TB] FAIL addi_decode got=%h exp=%h", to_decode, exp); end
    exp = sbQ.pop_front(); checks++;
    if ({16'd0, rInV} !== exp) begin failures++; $display("[TB] FAIL addi_rin got=%h exp=%h", rInV, exp); end
    sbQ.push_back(32'd12);
    cycle(); idle();
    exp = sbQ.pop_front(); checks++;
    if (busR[5] !== exp) begin failures++; $display("[TB] FAIL addi_result got=%h exp=%h", busR[5], exp); end
    loadIR(32'h00040000);
    Cout = 1; sbQ.push_back(32'hFFFC0000); #1;
    exp = sbQ.pop_front(); checks++;
    if (BusOut !== exp) begin failures++; $display("[TB] FAIL c_sign_ext got=%h exp=%h", BusOut, exp); end
    idle();
  endtask

  task automatic test_baout();
    loadR(4'd0, 32'h0000FFFF);
    Grb = 1; BAOut = 1; sbQ.push_back(32'd0); sbQ.push_back(32'h0001); #1;
    exp = sbQ.pop_front(); checks++;
    if (BusOut !== exp) begin failures++; $display("[TB] FAIL baout_r0 got=%h exp=%h", BusOut, exp); end
    exp = sbQ.pop_front(); checks++;
    if ({16'd0, rOutV} !== exp) begin failures++; $display("[TB] FAIL baout_rout got=%h exp=%h", rOutV, exp); end
    idle(); Grb = 1; Rout = 1; sbQ.push_back(32'h0000FFFF); #1;
    exp = sbQ.pop_front(); checks++;
    if (BusOut !== exp) begin failures++; $display("[TB] FAIL rout_r0 got=%h exp=%h", BusOut, exp); end
    idle();
  endtask

  task automatic test_branch();
    logic [31:0] regVal [6];
    logic [31:0] irVal [6];
    logic        conExp [6];
    regVal = '{32'd0, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    irVal  = '{32'h01000000, 32'h01000000, 32'h01080000, 32'h01100000, 32'h01180000, 32'h01100000};
    conExp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      loadR(4'd2, regVal[i]);
      loadIR(irVal[i]);
      Gra = 1; Rout = 1; CONin = 1;
      sbQ.push_back({31'd0, conExp[i]});
      cycle(); idle();
      exp = sbQ.pop_front(); checks++;
      if ({31'd0, branchCompare} !== exp) begin
        failures++; $display("[TB] FAIL branch_%0d got=%h exp=%h", i, branchCompare, exp);
      end
    end
  endtask

  task automatic test_priority();
    setInPort(32'h111); InPortout = 1; HIin = 1; cycle();
    setInPort(32'h222); InPortout = 1; LOin = 1; OutPortin = 1; cycle(); idle();
    sbQ.push_back(32'h222);
    exp = sbQ.pop_front(); checks++;
    if (output_data !== exp) begin failures++; $display("[TB] FAIL outport got=%h exp=%h", output_data, exp); end
    HIOut = 1; LOout = 1; sbQ.push_back(32'h111); #1;
    exp = sbQ.pop_front(); checks++;
    if (BusOut !== exp) begin failures++; $display("[TB] FAIL prio_hi_lo got=%h exp=%h", BusOut, exp); end
    idle();
    loadR(4'd3, 32'h333);
    Gra = 1; Rout = 1; HIOut = 1; InPortout = 1; sbQ.push_back(32'h333); #1;
    exp = sbQ.pop_front(); checks++;
    if (BusOut !== exp) begin failures++; $display("[TB] FAIL prio_reg got=%h exp=%h", BusOut, exp); end
    idle(); sbQ.push_back(32'd0); #1;
    exp = sbQ.pop_front(); checks++;
    if (BusOut !== exp) begin failures++; $display("[TB] FAIL bus_idle got=%h exp=%h", BusOut, exp); end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  o;
    logic        inc;
  } aluVec_t;

  task automatic test_alu_ops();
    aluVec_t vecs [$];
    logic [63:0] e;
    vecs.push_back('{32'hFFFFFFFF, 32'd2,        5'b00011, 1'b0});
    vecs.push_back('{32'd3,        32'd5,        5'b00100, 1'b0});
    vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 5'b00101, 1'b0});
    vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 5'b00110, 1'b0});
    vecs.push_back('{32'h80000000, 32'd4,        5'b00111, 1'b0});
    vecs.push_back('{32'h80000000, 32'd4,        5'b01000, 1'b0});
    vecs.push_back('{32'd1,        32'd31,       5'b01001, 1'b0});
    vecs.push_back('{32'd1,        32'd1,        5'b01010, 1'b0});
    vecs.push_back('{32'h12345678, 32'd0,        5'b01010, 1'b0});
    vecs.push_back('{32'h80000001, 32'h00000024, 5'b01011, 1'b0});
    vecs.push_back('{32'd0,        32'd5,        5'b10000, 1'b0});
    vecs.push_back('{32'd0,        32'h0000FFFF, 5'b10001, 1'b0});
    vecs.push_back('{32'd9,        32'd9,        5'b11111, 1'b0});
    vecs.push_back('{32'd9,        32'hFFFFFFFF, 5'b00011, 1'b1});
    vecs.push_back('{32'hFFFFFFF9, 32'd2,        5'b01111, 1'b0});
    vecs.push_back('{32'd100,      32'd0,        5'b01111, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 5'b01110, 1'b0});
    foreach (vecs[i]) begin
      loadY(vecs[i].a);
      setInPort(vecs[i].b);
      InPortout = 1; op = vecs[i].o; IncPC = vecs[i].inc; ZHighin = 1; Zlowin = 1;
      e = aluModel(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].inc);
      sbQ.push_back(e[63:32]); sbQ.push_back(e[31:0]);
      cycle(); idle();
      exp = sbQ.pop_front(); checks++;
      if (ZHighWire !== exp) begin
        failures++; $display("[TB] FAIL alu_%0d_hi op=%b got=%h exp=%h", i, vecs[i].o, ZHighWire, exp);
      end
      exp = sbQ.pop_front(); checks++;
      if (ZLowWire !== exp) begin
        failures++; $display("[TB] FAIL alu_%0d_lo op=%b got=%h exp=%h", i, vecs[i].o, ZLowWire, exp);
      end
    end
  endtask

  task automatic test_muldiv();
    loadY(32'hFFFFFFFF);
    setInPort(32'd2);
    InPortout = 1; op = 5'b01110; ZHighin = 1; Zlowin = 1;
`ifdef MULDIV_EN
    sbQ.push_back(32'hFFFFFFFF); sbQ.push_back(32'hFFFFFFFE);
`else
    sbQ.push_back(32'd0); sbQ.push_back(32'd0);
`endif
    cycle(); idle();
    exp = sbQ.pop_front(); checks++;
    if (ZHighWire !== exp) begin failures++; $display("[TB] FAIL mul_hi got=%h exp=%h", ZHighWire, exp); end
    exp = sbQ.pop_front(); checks++;
    if (ZLowWire !== exp) begin failures++; $display("[TB] FAIL mul_lo got=%h exp=%h", ZLowWire, exp); end
  endtask

  task automatic test_reset_override();
    setInPort(32'h55); InPortout = 1; PCin = 1; IRin = 1; Yin = 1; CONin = 1; clear = 0;
    sbQ.push_back(32'd0); sbQ.push_back(32'd0); sbQ.push_back(32'd0);
    sbQ.push_back(32'd0); sbQ.push_back(32'h0A880005);
    cycle(); idle();
    exp = sbQ.pop_front(); checks++;
    if (BusMuxInPCout !== exp) begin failures++; $display("[TB] FAIL rst_pc_override got=%h exp=%h", BusMuxInPCout, exp); end
    exp = sbQ.pop_front(); checks++;
    if (irOut !== exp) begin failures++; $display("[TB] FAIL rst_ir_override got=%h exp=%h", irOut, exp); end
    exp = sbQ.pop_front(); checks++;
    if (busR[5] !== exp) begin failures++; $display("[TB] FAIL rst_r5 got=%h exp=%h", busR[5], exp); end
    exp = sbQ.pop_front(); checks++;
    if (output_data !== exp) begin failures++; $display("[TB] FAIL rst_outport got=%h exp=%h", output_data, exp); end
    exp = sbQ.pop_front(); checks++;
    if (BusMuxInRamout !== exp) begin failures++; $display("[TB] FAIL rst_ram_kept got=%h exp=%h", BusMuxInRamout, exp); end
  endtask

  initial begin
    idle();
    test_reset();
    test_memory();
    test_fetch();
    test_immediate_add();
    test_baout();
    test_branch();
    test_priority();
    test_alu_ops();
    test_muldiv();
    test_reset_override();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_path_core.md
DATA_PATH_CORE -- requirements
Module: data_path

Interface
REQ-001 Parameter ADDR_W, default 9, RAM address width (2**ADDR_W words of 32 bits).
REQ-002 Ports SHALL appear in exactly the order listed in REQ-003..REQ-014, because instantiation is positional.
REQ-003 Clock  in  1  single clock; all state updates on rising edge.
REQ-004 clear  in  1  reset, synchronous, active-low.
REQ-005 Read, Write, strobe, BAOut, Gra, Grb, Grc, Rin, Rout, CONin  in  1 each  memory read/write, in-port strobe, base-address out, register-field selects, register in/out, CON-FF load.
REQ-006 input_data  in  32  in-port data.  IRin  in  1  IR load.  op  in  5  ALU opcode.
REQ-007 HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout  in  1 each  bus source enables.
REQ-008 HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC  in  1 each  register loads; IncPC forces ALU increment.
REQ-009 BusOut, mdrData, ZHighWire, ZLowWire  out  32 each  bus, MDR, Z[63:32], Z[31:0].
REQ-010 BusMuxInR0..BusMuxInR15  out  32 each  R0..R15 contents.
REQ-011 BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout, BusMuxInInPortout, BusMuxInYout, BusMuxInHI, BusMuxInLO, BusMuxInRamout  out  32 each  bus mux inputs (RAM = mem[MAR]).
REQ-012 output_data  out  32  out-port register.  irOut  out  32  IR.  branchCompare  out  1  CON FF.
REQ-013 R0out..R15out, then R0in..R15in  out  1 each  decoded register strobes.
REQ-014 to_decode  out  4  selected register field.

Function
REQ-015 IR fields: IR[31:27] opcode, Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C2=IR[20:19], C=IR[18:0] sign-extended to 32.
REQ-016 to_decode = Ra if Gra, else Rb if Grb, else Rc if Grc, else 0; Rxin = Rin & one-hot(to_decode); Rxout = (Rout|BAOut) & one-hot(to_decode).
REQ-017 Bus priority (first active wins): R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, Y, RAM, C; none active -> 0.
REQ-018 R0 selected with BAOut -> bus 0 regardless of R0 contents.
REQ-019 Registers R0..R15, HI, LO, Y, PC, IR, OutPort load bus on clock edge when respective in-strobe high.
REQ-020 ALU: A=Y, B=bus, 64-bit result; ZHighin loads result[63:32], Zlowin loads result[31:0], independently.
REQ-021 Opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol (shift amount B[4:0]), 01110 mul (signed 64-bit), 01111 div (Z high=remainder, low=quotient; B=0 -> result 0), 10000 neg B, 10001 not B; others -> 0; non-mul/div ops zero-extend into high half.
REQ-022 IncPC high -> result = bus+1, overriding op.
REQ-023 MAR loads bus[ADDR_W-1:0] on MARin; RAM read combinational from mem[MAR].
REQ-024 MDRin: loads mem[MAR] if Read, else bus. Write: mem[MAR] <= MDR on clock edge; Write and MDRin same cycle -> RAM gets old MDR.
REQ-025 InPort register loads input_data each edge strobe is high.
REQ-026 CONin: CON <= (C2=00: bus==0; 01: bus!=0; 10: bus[31]==0; 11: bus[31]==1).
REQ-027 Arithmetic wraps modulo 2**32 (add/sub/increment), no flags.

Reset
REQ-028 clear low at edge -> all registers, Y, Z, PC, IR, MAR, MDR, HI, LO, InPort, OutPort, CON = 0; RAM unchanged; reset overrides simultaneous loads.

Configuration
REQ-029 Macro MULDIV_EN: defined -> mul/div implemented per REQ-021; undefined -> opcodes 01110/01111 yield 0 and no multiplier/divider logic.

Structure
REQ-030 Package data_path_pkg: opcode constants, IR field positions, condition codes C2.
REQ-031 One sub-module dp_alu (A, B, op, IncPC -> 64-bit result); rest inline.

Verification
REQ-032 Reset: clear=0 one edge -> BusMuxInPCout=0, irOut=0, branchCompare=0.
REQ-033 Fetch: mem[0]=32'h0A880005, PCout+MARin+IncPC+ZHighin+Zlowin, then Zlowout+PCin, Read+MDRin, MDRout+IRin -> PC=1, irOut=32'h0A880005.
REQ-034 Immediate add: R1=7, IR Rb=1 C=5; Grb+BAOut+Yin, Cout+op=00011+Z loads, Zlowout+Gra+Rin -> Ra register=12.
REQ-035 BAOut with Rb=0, R0=32'hFFFF -> BusOut=0.
REQ-036 Branch: R2=0, IR Ra=2 C2=00, Gra+Rout+CONin -> branchCompare=1; R2=5 -> 0.
REQ-037 mul: Y=32'hFFFFFFFF, bus=2, op=01110 -> ZHighWire=32'hFFFFFFFF, ZLowWire=32'hFFFFFFFE.
